// File: rtl/switch_pkg.sv
// Shared definitions for the slide-switch debouncer: defaults, counter sizing
// and the per-bit qualification state encoding.
package switch_pkg;

    localparam int unsigned N_SW_DEFAULT            = 32'd5;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd500000;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        QUALIFY = 1'b1
    } db_state_e;

    // Bits needed to count 0..cycles-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = 32'd1;
        for (int unsigned k = 32'd1; k < 32'd32; k++) begin
            if ((64'd1 << k) < 64'(cycles)) begin
                w = k + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Bundle of the switch-side signals of switch_debouncer; the platform side
// drives raw pins, clears and masks, the debouncer returns the filtered view.
interface switch_debouncer_if
    import switch_pkg::*;
#(
    parameter int unsigned N_SW = N_SW_DEFAULT
);
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_stable;
    logic            sw_changed;
    logic [N_SW-1:0] edge_capture;
    logic [N_SW-1:0] edge_clear;
    logic [N_SW-1:0] irq_mask;
    logic            irq;

    modport master (
        output sw_raw, edge_clear, irq_mask,
        input  sw_stable, sw_changed, edge_capture, irq
    );

    modport slave (
        input  sw_raw, edge_clear, irq_mask,
        output sw_stable, sw_changed, edge_capture, irq
    );

endinterface

// File: rtl/debounce_bit.sv
// One switch channel: 2-flop synchronizer followed by a stability counter that
// only flips the accepted state after DEBOUNCE_CYCLES unbroken differing cycles.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic accept
);
    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1_r;
    logic             sync2_r;
    db_state_e        state_r;
    db_state_e        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             stable_r;
    logic             stable_s;
    logic             accept_s;

    // Metastability guard on the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Qualification state, counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            stable_r <= stable_s;
        end
    end

    // Any cycle where the synchronized pin agrees with the accepted level
    // aborts qualification, so a bounce restarts the count from scratch.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        stable_s = stable_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync2_r != stable_r) begin
                    state_s = QUALIFY;
                    cnt_s   = CNT_W'(1'b1);
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            QUALIFY: begin
                if (sync2_r == stable_r) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == LAST_CNT) begin
                    state_s  = IDLE;
                    cnt_s    = {CNT_W{1'b0}};
                    stable_s = ~stable_r;
                    accept_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign stable = stable_r;
    assign accept = accept_s;

endmodule

// File: rtl/switch_debouncer.sv
// N-channel slide-switch debouncer with sticky toggle capture and a maskable
// level interrupt, fronting the platform switches PIO.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int unsigned N_SW            = N_SW_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_stable,
    output logic            sw_changed,
    output logic [N_SW-1:0] edge_capture,
    input  logic [N_SW-1:0] edge_clear,
    input  logic [N_SW-1:0] irq_mask,
    output logic            irq
);
    logic [N_SW-1:0] accept_s;
    logic [N_SW-1:0] toggled_r;
    logic [N_SW-1:0] edge_capture_r;
    logic            sw_changed_r;
    logic            irq_r;

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk_clk),
            .rst_n  (reset_reset_n),
            .raw    (sw_raw[i]),
            .stable (sw_stable[i]),
            .accept (accept_s[i])
        );
    end

    // Change pulse lands with the new sw_stable; capture follows a cycle
    // later, and a fresh toggle overrides a coincident clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_changed_r   <= 1'b0;
            toggled_r      <= {N_SW{1'b0}};
            edge_capture_r <= {N_SW{1'b0}};
            irq_r          <= 1'b0;
        end else begin
            sw_changed_r   <= |accept_s;
            toggled_r      <= accept_s;
            edge_capture_r <= (edge_capture_r & ~edge_clear) | toggled_r;
            irq_r          <= |(edge_capture_r & irq_mask);
        end
    end

    assign sw_changed   = sw_changed_r;
    assign edge_capture = edge_capture_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (DEBOUNCE_CYCLES=8): directed scenarios plus a
// randomized run, all compared against a run-length reference model.
module tb_switch_debouncer;
    localparam int NSW = 5;
    localparam int DC  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    switch_debouncer_if #(.N_SW(NSW)) bus ();

    switch_debouncer #(
        .N_SW            (NSW),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sw_raw        (bus.sw_raw),
        .sw_stable     (bus.sw_stable),
        .sw_changed    (bus.sw_changed),
        .edge_capture  (bus.edge_capture),
        .edge_clear    (bus.edge_clear),
        .irq_mask      (bus.irq_mask),
        .irq           (bus.irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int chg_seen = 0;

    // Reference: raw is seen two cycles late; a bit's accepted level flips
    // once the delayed pin has disagreed with it for DC consecutive cycles.
    logic [NSW-1:0] m_dly [2];
    logic [NSW-1:0] m_stable, m_tog, m_ec;
    logic           m_chg, m_irq;
    int             run [NSW];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r_n, input logic [NSW-1:0] raw,
                              input logic [NSW-1:0] clr, input logic [NSW-1:0] mask);
        logic [NSW-1:0] tog;
        tog = '0;
        if (!r_n) begin
            m_dly[0] = '0; m_dly[1] = '0;
            m_stable = '0; m_tog = '0; m_ec = '0; m_chg = 1'b0; m_irq = 1'b0;
            for (int i = 0; i < NSW; i++) run[i] = 0;
        end else begin
            for (int i = 0; i < NSW; i++) begin
                if (m_dly[1][i] != m_stable[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == DC) begin
                        tog[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_irq    = |(m_ec & mask);
            m_ec     = (m_ec & ~clr) | m_tog;
            m_tog    = tog;
            m_chg    = |tog;
            m_stable = m_stable ^ tog;
            m_dly[1] = m_dly[0];
            m_dly[0] = raw;
        end
    endtask

    task automatic tick();
        logic           r_n;
        logic [NSW-1:0] raw, clr, mask;
        r_n  = rst_n;
        raw  = bus.sw_raw;
        clr  = bus.edge_clear;
        mask = bus.irq_mask;
        @(posedge clk);
        model_step(r_n, raw, clr, mask);
        #1;
        if (bus.sw_changed === 1'b1) chg_seen++;
        check_eq("m_stable",  32'(bus.sw_stable),    32'(m_stable));
        check_eq("m_changed", 32'(bus.sw_changed),   32'(m_chg));
        check_eq("m_edgecap", 32'(bus.edge_capture), 32'(m_ec));
        check_eq("m_irq",     32'(bus.irq),          32'(m_irq));
    endtask

    initial begin
        bus.sw_raw     = '0;
        bus.edge_clear = '0;
        bus.irq_mask   = '0;
        rst_n          = 1'b0;
        repeat (3) tick();
        check_eq("rst_stable", 32'(bus.sw_stable), 32'h0);
        check_eq("rst_edgecap", 32'(bus.edge_capture), 32'h0);
        check_eq("rst_irq", 32'(bus.irq), 32'h0);
        check_eq("rst_changed", 32'(bus.sw_changed), 32'h0);

        // quiet inputs after reset
        rst_n = 1'b1;
        chg_seen = 0;
        repeat (50) tick();
        check_eq("idle_stable", 32'(bus.sw_stable), 32'h0);
        check_eq("idle_chg_count", 32'(chg_seen), 32'h0);
        check_eq("idle_irq", 32'(bus.irq), 32'h0);

        // clean rising edge on bit 0
        bus.sw_raw = 5'b00001;
        chg_seen = 0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 9)  check_eq("edge_c9_stable", 32'(bus.sw_stable), 32'h0);
            if (c == 10) check_eq("edge_c10_stable", 32'(bus.sw_stable), 32'h1);
            if (c == 10) check_eq("edge_c10_changed", 32'(bus.sw_changed), 32'h1);
            if (c == 11) check_eq("edge_c11_edgecap", 32'(bus.edge_capture), 32'h1);
        end
        check_eq("edge_chg_count", 32'(chg_seen), 32'h1);

        // short glitch on bit 2 is rejected
        bus.sw_raw = 5'b00101;
        repeat (5) tick();
        bus.sw_raw = 5'b00001;
        repeat (20) tick();
        check_eq("glitch_stable", 32'(bus.sw_stable), 32'h1);
        check_eq("glitch_edgecap", 32'(bus.edge_capture), 32'h1);

        // interrupt, clear, then set-wins-over-clear
        bus.irq_mask = 5'b00001;
        tick();
        check_eq("irq_on", 32'(bus.irq), 32'h1);
        bus.edge_clear = 5'b00001;
        tick();
        bus.edge_clear = 5'b00000;
        check_eq("clr_edgecap", 32'(bus.edge_capture), 32'h0);
        check_eq("clr_irq_lag", 32'(bus.irq), 32'h1);
        tick();
        check_eq("clr_irq_off", 32'(bus.irq), 32'h0);
        bus.sw_raw = 5'b00000;
        repeat (10) tick();
        check_eq("fall_stable", 32'(bus.sw_stable), 32'h0);
        bus.edge_clear = 5'b00001;
        tick();
        bus.edge_clear = 5'b00000;
        check_eq("set_wins_edgecap", 32'(bus.edge_capture), 32'h1);
        tick();
        check_eq("set_wins_irq", 32'(bus.irq), 32'h1);

        // three bits together: one pulse
        bus.edge_clear = 5'b11111;
        tick();
        bus.edge_clear = 5'b00000;
        check_eq("multi_clr", 32'(bus.edge_capture), 32'h0);
        bus.sw_raw = 5'b10101;
        chg_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 9)  check_eq("multi_c9_stable", 32'(bus.sw_stable), 32'h0);
            if (c == 10) check_eq("multi_c10_stable", 32'(bus.sw_stable), 32'h15);
            if (c == 10) check_eq("multi_c10_changed", 32'(bus.sw_changed), 32'h1);
        end
        check_eq("multi_chg_count", 32'(chg_seen), 32'h1);
        check_eq("multi_edgecap", 32'(bus.edge_capture), 32'h15);

        // reset mid-qualify on bit 1 (count at 5 after 7 edges)
        bus.sw_raw = 5'b00010;
        repeat (7) tick();
        check_eq("preq_stable", 32'(bus.sw_stable), 32'h15);
        rst_n = 1'b0;
        #2;
        check_eq("async_rst_stable", 32'(bus.sw_stable), 32'h0);
        check_eq("async_rst_edgecap", 32'(bus.edge_capture), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 9)  check_eq("postrst_c9_stable", 32'(bus.sw_stable), 32'h0);
            if (c == 10) check_eq("postrst_c10_stable", 32'(bus.sw_stable), 32'h2);
            if (c == 11) check_eq("postrst_c11_edgecap", 32'(bus.edge_capture), 32'h2);
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0)
                bus.sw_raw = bus.sw_raw ^ (5'b00001 << $urandom_range(0, NSW - 1));
            bus.edge_clear = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b00000;
            if ($urandom_range(0, 29) == 0) bus.irq_mask = 5'($urandom);
            rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
